arbiter2_rr: RTL and testbench
==============================

ARBITER2_RR -- requirements
Module: arbiter2_rr

Interface
REQ-001 SHALL have parameter W, default 9: packet width, applies to in0_data, in1_data and out_data.
REQ-002 SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port RESET, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have ports in0_valid input 1 / in0_ready output 1 / in0_data input W: requester 0 packet channel.
REQ-005 SHALL have ports in1_valid input 1 / in1_ready output 1 / in1_data input W: requester 1 packet channel.
REQ-006 SHALL have ports s_valid output 1 / s_ready input 1 / s_data output 1: source-select token, 0 = packet from in0, 1 = from in1.
REQ-007 SHALL have ports out_valid output 1 / out_ready input 1 / out_data output W: shared output channel, feeding the downstream address decoder.
REQ-008 SHALL have ports gcnt0 and gcnt1, output, 8 bits each: saturating grant counters for in0 and in1.

Function
REQ-009 SHALL implement an FSM with states IDLE, SEND_S and SEND_OUT.
REQ-010 SHALL transfer a packet on any channel only in a cycle where valid and ready are both 1 at the rising edge.
REQ-011 SHALL hold each output valid, and its data, stable until accepted, never deasserting valid before the handshake.
REQ-012 SHALL, in IDLE, grant in0 when only in0_valid=1 and grant in1 when only in1_valid=1.
REQ-013 SHALL, in IDLE with both valid, grant the input selected by the 1-bit priority pointer prio (0 = in0 first).
REQ-014 SHALL drive inN_ready combinationally: 1 only in IDLE for the granted input with inN_valid=1; at most one ready is high per cycle.
REQ-015 SHALL, on an input handshake, register the packet into data_q and the winner index into src_q, then enter SEND_S.
REQ-016 SHALL, in SEND_S, drive s_valid=1 and s_data=src_q, and enter SEND_OUT on s_ready=1.
REQ-017 SHALL, in SEND_OUT, drive out_valid=1 and out_data=data_q, and return to IDLE on out_ready=1.
REQ-018 SHALL, on the out handshake, set prio to the complement of src_q so the loser of the next tie wins.
REQ-019 SHALL, on an input handshake, increment the winner's gcnt, saturating at 255.
REQ-020 SHALL order every packet's S token strictly before its Out packet, with no overlap.
REQ-021 SHALL have latency: input accept at edge t, s_valid high after t, out_valid high no earlier than the edge after the s handshake; minimum 3 cycles per packet.
REQ-022 SHALL ignore changes on in0_valid, in1_valid or in data while not in IDLE; no second packet is buffered.
REQ-023 SHALL leave data_q unchanged while outside IDLE.

Reset
REQ-024 SHALL, on RESET=1, immediately force: state IDLE, prio 0, data_q 0, src_q 0, gcnt0/gcnt1 0.
REQ-025 SHALL, during reset, hold outputs at: s_valid 0, s_data 0, out_valid 0, out_data 0, in0_ready 0, in1_ready 0.
REQ-026 SHALL, on RESET asserted mid-packet in SEND_S or SEND_OUT, silently discard the in-flight packet with no S or Out emitted.
REQ-027 SHALL resume arbitration on the first rising edge after RESET deasserts.

Verification
REQ-028 SHALL cover a single requester: in0_valid=1, data 9'h1A5, s_ready=out_ready=1 -> in0_ready pulse, s_data=0, then out_data=9'h1A5; gcnt0=1, prio=1.
REQ-029 SHALL cover a tie from reset: both valid with data 9'h0F0 / 9'h10F -> order S=0, out 9'h0F0, S=1, out 9'h10F, then in0 wins the next tie.
REQ-030 SHALL cover backpressure: out_ready=0 for 5 cycles in SEND_OUT -> out_valid and out_data stable, both in readies 0, then exactly one transfer when out_ready=1.
REQ-031 SHALL cover reset mid-operation: RESET pulsed in SEND_S -> s_valid drops asynchronously, no out transfer, and all counters read 0.
REQ-032 SHALL cover saturation: 260 in1 packets with in0 idle -> gcnt1=255, gcnt0=0, with S tokens all 1.

Source files
------------

// File: rtl/arbiter2_rr_if.sv
// Packet channels, source-select token, shared output and grant counters of the 2:1 arbiter.
interface arbiter2_rr_if #(
    parameter int unsigned W = 9
);
    localparam int unsigned GCNT_W = 8;

    logic              in0_valid;
    logic              in0_ready;
    logic [W-1:0]      in0_data;
    logic              in1_valid;
    logic              in1_ready;
    logic [W-1:0]      in1_data;
    logic              s_valid;
    logic              s_ready;
    logic              s_data;
    logic              out_valid;
    logic              out_ready;
    logic [W-1:0]      out_data;
    logic [GCNT_W-1:0] gcnt0;
    logic [GCNT_W-1:0] gcnt1;

    // Environment side: requesters, token sink and downstream decoder
    modport master (
        output in0_valid, in0_data, in1_valid, in1_data, s_ready, out_ready,
        input  in0_ready, in1_ready, s_valid, s_data, out_valid, out_data, gcnt0, gcnt1
    );

    // Arbiter side
    modport slave (
        input  in0_valid, in0_data, in1_valid, in1_data, s_ready, out_ready,
        output in0_ready, in1_ready, s_valid, s_data, out_valid, out_data, gcnt0, gcnt1
    );
endinterface

// File: rtl/arbiter2_rr.sv
// Two-input round-robin packet arbiter: accepts one packet, emits its source token, then the packet.
module arbiter2_rr #(
    parameter int unsigned W = 9
) (
    input  logic         CLK,
    input  logic         RESET,
    arbiter2_rr_if.slave bus
);
    localparam int unsigned GCNT_W = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SEND_S   = 2'd1,
        SEND_OUT = 2'd2
    } state_t;

    state_t            state_q;
    logic              prio_q;
    logic              src_q;
    logic [W-1:0]      data_q;
    logic              s_valid_q;
    logic              out_valid_q;
    logic [GCNT_W-1:0] gcnt0_q;
    logic [GCNT_W-1:0] gcnt1_q;

    logic              grant1_c;
    logic              take_c;

    // in1 wins when it is the only requester, or on a tie when the pointer favours it
    assign grant1_c = bus.in1_valid && (!bus.in0_valid || prio_q);
    assign take_c   = (state_q == IDLE) && (bus.in0_valid || bus.in1_valid);

    // Readies are combinational; gated by RESET since the state is forced to IDLE during reset
    assign bus.in0_ready = !RESET && (state_q == IDLE) && bus.in0_valid && !grant1_c;
    assign bus.in1_ready = !RESET && (state_q == IDLE) && grant1_c;

    assign bus.s_valid   = s_valid_q;
    assign bus.s_data    = src_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = data_q;
    assign bus.gcnt0     = gcnt0_q;
    assign bus.gcnt1     = gcnt1_q;

    // Arbitration FSM: capture winner, hand out token, then packet; update pointer and counters
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= IDLE;
            prio_q      <= 1'b0;
            src_q       <= 1'b0;
            data_q      <= '0;
            s_valid_q   <= 1'b0;
            out_valid_q <= 1'b0;
            gcnt0_q     <= '0;
            gcnt1_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (take_c) begin
                        src_q     <= grant1_c;
                        data_q    <= grant1_c ? bus.in1_data : bus.in0_data;
                        s_valid_q <= 1'b1;
                        state_q   <= SEND_S;
                        if (grant1_c) begin
                            if (gcnt1_q != '1) gcnt1_q <= gcnt1_q + GCNT_W'(1);
                        end else begin
                            if (gcnt0_q != '1) gcnt0_q <= gcnt0_q + GCNT_W'(1);
                        end
                    end
                end
                SEND_S: begin
                    if (bus.s_ready) begin
                        s_valid_q   <= 1'b0;
                        out_valid_q <= 1'b1;
                        state_q     <= SEND_OUT;
                    end
                end
                SEND_OUT: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        prio_q      <= ~src_q;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    s_valid_q   <= 1'b0;
                    out_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_arbiter2_rr.sv
// Bench for arbiter2_rr: per-cycle comparison against a packet-level model, plus directed scenarios.
module tb_arbiter2_rr;
    localparam int unsigned W = 9;

    logic CLK   = 1'b0;
    logic RESET = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    arbiter2_rr_if #(.W(W)) bus ();

    arbiter2_rr #(.W(W)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- packet-level reference model ----------------
    // A packet is either waiting for its token to be taken, waiting to be delivered, or absent.
    int           m_prio     = 0;
    bit           m_tok_owed = 1'b0;
    bit           m_pkt_owed = 1'b0;
    int           m_src      = 0;
    logic [W-1:0] m_data     = '0;
    int           m_grants[2] = '{0, 0};

    function automatic void exp_ready(output bit r0, output bit r1);
        r0 = 1'b0;
        r1 = 1'b0;
        if (!RESET && !m_tok_owed && !m_pkt_owed) begin
            if (bus.in0_valid && bus.in1_valid) begin
                if (m_prio == 0) r0 = 1'b1;
                else             r1 = 1'b1;
            end else begin
                r0 = bus.in0_valid;
                r1 = bus.in1_valid;
            end
        end
    endfunction

    always @(posedge CLK or posedge RESET) begin
        bit r0, r1;
        if (RESET) begin
            m_prio = 0; m_tok_owed = 1'b0; m_pkt_owed = 1'b0; m_src = 0; m_data = '0;
            m_grants[0] = 0; m_grants[1] = 0;
        end else begin
            exp_ready(r0, r1);
            if (m_pkt_owed) begin
                if (bus.out_ready) begin
                    m_pkt_owed = 1'b0;
                    m_prio     = 1 - m_src;
                end
            end else if (m_tok_owed) begin
                if (bus.s_ready) begin
                    m_tok_owed = 1'b0;
                    m_pkt_owed = 1'b1;
                end
            end else if (r0 || r1) begin
                m_src      = r1 ? 1 : 0;
                m_data     = r1 ? bus.in1_data : bus.in0_data;
                m_tok_owed = 1'b1;
                if (m_grants[m_src] < 255) m_grants[m_src]++;
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge CLK) begin
        bit r0, r1;
        exp_ready(r0, r1);
        chk("in0_ready", 32'(bus.in0_ready), 32'(r0));
        chk("in1_ready", 32'(bus.in1_ready), 32'(r1));
        chk("s_valid",   32'(bus.s_valid),   32'(m_tok_owed));
        if (m_tok_owed) chk("s_data", 32'(bus.s_data), 32'(m_src));
        chk("out_valid", 32'(bus.out_valid), 32'(m_pkt_owed));
        if (m_pkt_owed) chk("out_data", 32'(bus.out_data), 32'(m_data));
        chk("gcnt0", 32'(bus.gcnt0), 32'(m_grants[0]));
        chk("gcnt1", 32'(bus.gcnt1), 32'(m_grants[1]));
    end

    // Handshake counters for transfer-count checks
    int out_hs = 0;
    int s_hs   = 0;
    int s_one  = 0;
    always @(posedge CLK) begin
        if (bus.out_valid && bus.out_ready) out_hs++;
        if (bus.s_valid && bus.s_ready) begin
            s_hs++;
            if (bus.s_data) s_one++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic next();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        bus.in0_valid = 1'b1; bus.in1_valid = 1'b1;
        bus.s_ready = 1'b1;   bus.out_ready = 1'b1;
        @(negedge CLK);
        chk("rst_in0_ready", 32'(bus.in0_ready), 32'd0);
        chk("rst_in1_ready", 32'(bus.in1_ready), 32'd0);
        chk("rst_s_valid",   32'(bus.s_valid),   32'd0);
        chk("rst_s_data",    32'(bus.s_data),    32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data",  32'(bus.out_data),  32'd0);
        chk("rst_gcnt0",     32'(bus.gcnt0),     32'd0);
        chk("rst_gcnt1",     32'(bus.gcnt1),     32'd0);
        next();
        RESET = 1'b0;
        bus.in0_valid = 1'b0; bus.in1_valid = 1'b0;
    endtask

    initial begin
        int base;
        bus.in0_valid = 1'b0; bus.in1_valid = 1'b0;
        bus.in0_data  = '0;   bus.in1_data  = '0;
        bus.s_ready   = 1'b0; bus.out_ready = 1'b0;

        // Single requester
        do_reset();
        bus.in0_valid = 1'b1; bus.in0_data = 9'h1A5;
        @(negedge CLK);
        chk("single_in0_ready", 32'(bus.in0_ready), 32'd1);
        chk("single_in1_ready", 32'(bus.in1_ready), 32'd0);
        next(); bus.in0_valid = 1'b0;
        @(negedge CLK);
        chk("single_s_valid", 32'(bus.s_valid), 32'd1);
        chk("single_s_data",  32'(bus.s_data),  32'd0);
        chk("single_gcnt0",   32'(bus.gcnt0),   32'd1);
        next();
        @(negedge CLK);
        chk("single_out_valid", 32'(bus.out_valid), 32'd1);
        chk("single_out_data",  32'(bus.out_data),  32'h1A5);
        chk("single_s_low",     32'(bus.s_valid),   32'd0);
        next();
        @(negedge CLK);
        chk("single_out_done", 32'(bus.out_valid), 32'd0);
        bus.in0_valid = 1'b1; bus.in1_valid = 1'b1;
        #1;
        chk("single_prio_in1", 32'(bus.in1_ready), 32'd1);
        chk("single_prio_in0", 32'(bus.in0_ready), 32'd0);

        // Tie from reset, both requesters held valid
        do_reset();
        bus.in0_valid = 1'b1; bus.in1_valid = 1'b1;
        bus.in0_data = 9'h0F0; bus.in1_data = 9'h10F;
        @(negedge CLK);
        chk("tie_first_in0", 32'(bus.in0_ready), 32'd1);
        chk("tie_first_in1", 32'(bus.in1_ready), 32'd0);
        next(); @(negedge CLK);
        chk("tie_s0", 32'(bus.s_data), 32'd0);
        next(); @(negedge CLK);
        chk("tie_out0", 32'(bus.out_data), 32'h0F0);
        next(); @(negedge CLK);
        chk("tie_second_in1", 32'(bus.in1_ready), 32'd1);
        chk("tie_second_in0", 32'(bus.in0_ready), 32'd0);
        next(); @(negedge CLK);
        chk("tie_s1", 32'(bus.s_data), 32'd1);
        next(); @(negedge CLK);
        chk("tie_out1", 32'(bus.out_data), 32'h10F);
        next(); @(negedge CLK);
        chk("tie_third_in0", 32'(bus.in0_ready), 32'd1);
        chk("tie_gcnt0", 32'(bus.gcnt0), 32'd1);
        chk("tie_gcnt1", 32'(bus.gcnt1), 32'd1);
        bus.in0_valid = 1'b0; bus.in1_valid = 1'b0;
        next();

        // Backpressure on the output channel, with input noise while busy
        bus.in0_valid = 1'b1; bus.in0_data = 9'h055; bus.out_ready = 1'b0;
        base = out_hs;
        @(negedge CLK);
        chk("bp_accept", 32'(bus.in0_ready), 32'd1);
        next(); bus.in1_valid = 1'b1;
        next();
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_out_data",  32'(bus.out_data),  32'h055);
            chk("bp_in0_ready", 32'(bus.in0_ready), 32'd0);
            chk("bp_in1_ready", 32'(bus.in1_ready), 32'd0);
            next();
            bus.in0_data = W'($urandom); bus.in1_data = W'($urandom);
        end
        bus.out_ready = 1'b1; bus.in0_valid = 1'b0; bus.in1_valid = 1'b0;
        @(negedge CLK);
        chk("bp_still_valid", 32'(bus.out_valid), 32'd1);
        next(); @(negedge CLK);
        chk("bp_released", 32'(bus.out_valid), 32'd0);
        chk("bp_one_transfer", 32'(out_hs - base), 32'd1);

        // Reset while the token is pending
        bus.in1_valid = 1'b1; bus.in1_data = 9'h133; bus.s_ready = 1'b0;
        base = out_hs;
        next(); bus.in1_valid = 1'b0;
        @(negedge CLK);
        chk("mid_s_valid", 32'(bus.s_valid), 32'd1);
        chk("mid_s_data",  32'(bus.s_data),  32'd1);
        #2 RESET = 1'b1;
        #1;
        chk("mid_s_drop",    32'(bus.s_valid),   32'd0);
        chk("mid_out_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_gcnt0",     32'(bus.gcnt0),     32'd0);
        chk("mid_gcnt1",     32'(bus.gcnt1),     32'd0);
        next(); RESET = 1'b0; bus.s_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            chk("mid_no_out", 32'(bus.out_valid), 32'd0);
            next();
        end
        chk("mid_no_transfer", 32'(out_hs - base), 32'd0);

        // Randomized traffic with occasional asynchronous resets
        for (int i = 0; i < 3000; i++) begin
            bus.in0_valid = 1'($urandom_range(0, 1));
            bus.in1_valid = 1'($urandom_range(0, 1));
            bus.in0_data  = W'($urandom);
            bus.in1_data  = W'($urandom);
            bus.s_ready   = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            RESET         = ($urandom_range(0, 199) == 0);
            next();
        end
        RESET = 1'b0;

        // Saturation of the in1 grant counter
        do_reset();
        base = s_hs;
        s_one = 0;
        bus.in1_valid = 1'b1;
        for (int i = 0; i < 800; i++) begin
            bus.in1_data = W'($urandom);
            next();
        end
        bus.in1_valid = 1'b0;
        @(negedge CLK);
        chk("sat_gcnt1", 32'(bus.gcnt1), 32'd255);
        chk("sat_gcnt0", 32'(bus.gcnt0), 32'd0);
        chk("sat_enough_pkts", 32'(s_hs - base >= 260), 32'd1);
        chk("sat_tokens_all_1", 32'(s_one), 32'(s_hs - base));
        next(); next(); next();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "timeout");
    end
endmodule
